// File: rtl/alu_branch_control.sv
// alu_branch_control
//   ID stage: decodes INSTRUCTION into control fields, which are latched into the
//   ID/EX control register.
//   EX stage: drives the ALU and the branch comparator from the registered fields
//   and from the forwarded operands.
//
// Ports
//   CLK, RESET          pipeline clock (rising edge) and asynchronous active-low reset
//   INSTRUCTION         ID-stage instruction word
//   STALL               holds the ID/EX control register
//   OP1, OP2            forwarded rs1/rs2 data for the EX stage
//   PC_EX, IMM_EX       PC and immediate of the EX instruction
//   IMMEDIATE_SELECT    immediate format of INSTRUCTION (combinational)
//   ALU_OUT             EX result (combinational)
//   BRANCH_TAKEN        redirect/flush request (combinational)
//   MEM_READ            registered {en, funct3}
//   MEM_WRITE           registered {en, funct3[1:0]}
//   REG_WRITE_EN        registered
//   REG_WRITE_SELECT    registered: 00 memory, 01 ALU, 11 PC+4 link
//
// Build option
//   RV32M_EN  when defined, the M extension (multiply/divide) is decoded and executed;
//             otherwise those encodings are NOPs and no multiplier/divider exists.
module alu_branch_control (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTRUCTION,
  input  logic        STALL,
  input  logic [31:0] OP1,
  input  logic [31:0] OP2,
  input  logic [31:0] PC_EX,
  input  logic [31:0] IMM_EX,
  output logic [3:0]  IMMEDIATE_SELECT,
  output logic [31:0] ALU_OUT,
  output logic        BRANCH_TAKEN,
  output logic [3:0]  MEM_READ,
  output logic [2:0]  MEM_WRITE,
  output logic        REG_WRITE_EN,
  output logic [1:0]  REG_WRITE_SELECT
);

  typedef struct packed {
    logic [5:0] alu_sel;   // [5] FWD, [4] M, [3] alt, [2:0] funct3
    logic [3:0] br_sel;    // {1, funct3} conditional, 1010 jump, 0000 none
    logic       op1_sel;   // 1: PC
    logic       op2_sel;   // 1: immediate
    logic [3:0] mem_read;
    logic [2:0] mem_write;
    logic       reg_we;
    logic [1:0] reg_wsel;
  } ctrl_t;

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  ctrl_t      w_dec;
  ctrl_t      r_ctrl;
  logic [3:0] w_imm_sel;
  logic       w_unused_instr;

  assign w_opcode       = INSTRUCTION[6:0];
  assign w_funct3       = INSTRUCTION[14:12];
  assign w_funct7       = INSTRUCTION[31:25];
  // register specifiers are resolved by the register file, not here
  assign w_unused_instr = ^{INSTRUCTION[24:15], INSTRUCTION[11:7]};

  // ---------------- decode ----------------
  always_comb begin
    w_dec     = '0;
    w_imm_sel = 4'b0000;
    case (w_opcode)
      7'b0110111: begin // LUI
        w_dec.alu_sel  = 6'b100000;
        w_dec.op2_sel  = 1'b1;
        w_dec.reg_we   = 1'b1;
        w_dec.reg_wsel = 2'b01;
        w_imm_sel      = 4'b0100;
      end
      7'b0010111: begin // AUIPC
        w_dec.op1_sel  = 1'b1;
        w_dec.op2_sel  = 1'b1;
        w_dec.reg_we   = 1'b1;
        w_dec.reg_wsel = 2'b01;
        w_imm_sel      = 4'b0100;
      end
      7'b1101111: begin // JAL
        w_dec.op1_sel  = 1'b1;
        w_dec.op2_sel  = 1'b1;
        w_dec.br_sel   = 4'b1010;
        w_dec.reg_we   = 1'b1;
        w_dec.reg_wsel = 2'b11;
        w_imm_sel      = 4'b0101;
      end
      7'b1100111: begin // JALR
        w_dec.op2_sel  = 1'b1;
        w_dec.br_sel   = 4'b1010;
        w_dec.reg_we   = 1'b1;
        w_dec.reg_wsel = 2'b11;
        w_imm_sel      = 4'b0001;
      end
      7'b1100011: begin // BRANCH
        if (w_funct3 != 3'b010 && w_funct3 != 3'b011) begin
          w_dec.op1_sel = 1'b1;
          w_dec.op2_sel = 1'b1;
          w_dec.br_sel  = {1'b1, w_funct3};
          w_imm_sel     = 4'b0011;
        end
      end
      7'b0000011: begin // LOAD
        if (w_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) begin
          w_dec.op2_sel  = 1'b1;
          w_dec.mem_read = {1'b1, w_funct3};
          w_dec.reg_we   = 1'b1;
          w_dec.reg_wsel = 2'b00;
          w_imm_sel      = 4'b0001;
        end
      end
      7'b0100011: begin // STORE
        if (w_funct3 inside {3'b000, 3'b001, 3'b010}) begin
          w_dec.op2_sel   = 1'b1;
          w_dec.mem_write = {1'b1, w_funct3[1:0]};
          w_imm_sel       = 4'b0010;
        end
      end
      7'b0010011: begin // OP-IMM; bit 30 is immediate data except for SRLI/SRAI
        w_dec.alu_sel  = {2'b00, (w_funct3 == 3'b101) & INSTRUCTION[30], w_funct3};
        w_dec.op2_sel  = 1'b1;
        w_dec.reg_we   = 1'b1;
        w_dec.reg_wsel = 2'b01;
        w_imm_sel      = 4'b0001;
      end
      7'b0110011: begin // OP
        if (w_funct7 == 7'b0000000 ||
            (w_funct7 == 7'b0100000 && (w_funct3 == 3'b000 || w_funct3 == 3'b101))) begin
          w_dec.alu_sel  = {2'b00, w_funct7[5], w_funct3};
          w_dec.reg_we   = 1'b1;
          w_dec.reg_wsel = 2'b01;
        end
`ifdef RV32M_EN
        else if (w_funct7 == 7'b0000001) begin
          w_dec.alu_sel  = {3'b010, w_funct3};
          w_dec.reg_we   = 1'b1;
          w_dec.reg_wsel = 2'b01;
        end
`endif
      end
      default: ;
    endcase
  end

  assign IMMEDIATE_SELECT = w_imm_sel;

  // ---------------- ID/EX control register ----------------
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_ctrl <= '0;
    end else if (!STALL) begin
      // a taken branch in EX squashes the instruction leaving ID
      if (BRANCH_TAKEN) r_ctrl <= '0;
      else              r_ctrl <= w_dec;
    end
  end

  assign MEM_READ         = r_ctrl.mem_read;
  assign MEM_WRITE        = r_ctrl.mem_write;
  assign REG_WRITE_EN     = r_ctrl.reg_we;
  assign REG_WRITE_SELECT = r_ctrl.reg_wsel;

  // ---------------- execute ----------------
  logic [31:0] w_in1;
  logic [31:0] w_in2;
  logic [4:0]  w_shamt;
  logic [31:0] w_alu_raw;
  logic        w_is_jalr;

  assign w_in1     = r_ctrl.op1_sel ? PC_EX : OP1;
  assign w_in2     = r_ctrl.op2_sel ? IMM_EX : OP2;
  assign w_shamt   = w_in2[4:0];
  // only JALR jumps with an rs1 base; JAL's PC-relative sum is left untouched
  assign w_is_jalr = (r_ctrl.br_sel == 4'b1010) && !r_ctrl.op1_sel;

`ifdef RV32M_EN
  logic        w_sgn_a;
  logic        w_sgn_b;
  logic [63:0] w_mul_a;
  logic [63:0] w_mul_b;
  logic [63:0] w_prod;
  logic        w_div_zero;
  logic        w_div_ovf;
  logic [31:0] w_quot_s;
  logic [31:0] w_rem_s;
  logic [31:0] w_div_res;
  logic [31:0] w_divu_res;
  logic [31:0] w_rem_res;
  logic [31:0] w_remu_res;

  // one 64x64 product serves all four multiplies; low 64 bits are exact for
  // every signedness combination once the operands are extended accordingly
  assign w_sgn_a    = (r_ctrl.alu_sel[1:0] != 2'b11);
  assign w_sgn_b    = (r_ctrl.alu_sel[1:0] == 2'b01);
  assign w_mul_a    = {{32{w_sgn_a & w_in1[31]}}, w_in1};
  assign w_mul_b    = {{32{w_sgn_b & w_in2[31]}}, w_in2};
  assign w_prod     = w_mul_a * w_mul_b;

  assign w_div_zero = (w_in2 == 32'h0);
  assign w_div_ovf  = (w_in1 == 32'h8000_0000) && (w_in2 == 32'hFFFF_FFFF);
  assign w_quot_s   = $signed(w_in1) / $signed(w_in2);
  assign w_rem_s    = $signed(w_in1) % $signed(w_in2);
  assign w_div_res  = w_div_zero ? 32'hFFFF_FFFF : (w_div_ovf ? 32'h8000_0000 : w_quot_s);
  assign w_rem_res  = w_div_zero ? w_in1 : (w_div_ovf ? 32'h0 : w_rem_s);
  assign w_divu_res = w_div_zero ? 32'hFFFF_FFFF : (w_in1 / w_in2);
  assign w_remu_res = w_div_zero ? w_in1 : (w_in1 % w_in2);
`endif

  always_comb begin
    w_alu_raw = 32'h0;
    case (r_ctrl.alu_sel)
      6'b000000: w_alu_raw = w_in1 + w_in2;
      6'b001000: w_alu_raw = w_in1 - w_in2;
      6'b000001: w_alu_raw = w_in1 << w_shamt;
      6'b000010: w_alu_raw = {31'h0, $signed(w_in1) < $signed(w_in2)};
      6'b000011: w_alu_raw = {31'h0, w_in1 < w_in2};
      6'b000100: w_alu_raw = w_in1 ^ w_in2;
      6'b000101: w_alu_raw = w_in1 >> w_shamt;
      6'b001101: w_alu_raw = $signed(w_in1) >>> w_shamt;
      6'b000110: w_alu_raw = w_in1 | w_in2;
      6'b000111: w_alu_raw = w_in1 & w_in2;
      6'b100000: w_alu_raw = w_in2;
`ifdef RV32M_EN
      6'b010000: w_alu_raw = w_prod[31:0];
      6'b010001,
      6'b010010,
      6'b010011: w_alu_raw = w_prod[63:32];
      6'b010100: w_alu_raw = w_div_res;
      6'b010101: w_alu_raw = w_divu_res;
      6'b010110: w_alu_raw = w_rem_res;
      6'b010111: w_alu_raw = w_remu_res;
`endif
      default:   w_alu_raw = 32'h0;
    endcase
  end

  assign ALU_OUT = w_is_jalr ? {w_alu_raw[31:1], 1'b0} : w_alu_raw;

  // comparator works on the forwarded registers, never on the immediate path
  always_comb begin
    BRANCH_TAKEN = 1'b0;
    case (r_ctrl.br_sel)
      4'b1000: BRANCH_TAKEN = (OP1 == OP2);
      4'b1001: BRANCH_TAKEN = (OP1 != OP2);
      4'b1100: BRANCH_TAKEN = ($signed(OP1) <  $signed(OP2));
      4'b1101: BRANCH_TAKEN = ($signed(OP1) >= $signed(OP2));
      4'b1110: BRANCH_TAKEN = (OP1 <  OP2);
      4'b1111: BRANCH_TAKEN = (OP1 >= OP2);
      4'b1010: BRANCH_TAKEN = 1'b1;
      default: BRANCH_TAKEN = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_alu_branch_control.sv
module tb_alu_branch_control;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] INSTRUCTION;
  logic        STALL;
  logic [31:0] OP1, OP2, PC_EX, IMM_EX;
  logic [3:0]  IMMEDIATE_SELECT;
  logic [31:0] ALU_OUT;
  logic        BRANCH_TAKEN;
  logic [3:0]  MEM_READ;
  logic [2:0]  MEM_WRITE;
  logic        REG_WRITE_EN;
  logic [1:0]  REG_WRITE_SELECT;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef RV32M_EN
  localparam bit HAS_M = 1'b1;
`else
  localparam bit HAS_M = 1'b0;
`endif

  alu_branch_control dut (
    .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION), .STALL(STALL),
    .OP1(OP1), .OP2(OP2), .PC_EX(PC_EX), .IMM_EX(IMM_EX),
    .IMMEDIATE_SELECT(IMMEDIATE_SELECT), .ALU_OUT(ALU_OUT), .BRANCH_TAKEN(BRANCH_TAKEN),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .REG_WRITE_EN(REG_WRITE_EN),
    .REG_WRITE_SELECT(REG_WRITE_SELECT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef enum int {
    M_LUI, M_AUIPC, M_JAL, M_JALR,
    M_BEQ, M_BNE, M_BLT, M_BGE, M_BLTU, M_BGEU,
    M_LB, M_LH, M_LW, M_LBU, M_LHU, M_SB, M_SH, M_SW,
    M_ADDI, M_SLTI, M_SLTIU, M_XORI, M_ORI, M_ANDI, M_SLLI, M_SRLI, M_SRAI,
    M_ADD, M_SUB, M_SLL, M_SLT, M_SLTU, M_XOR, M_SRL, M_SRA, M_OR, M_AND,
    M_MUL, M_MULH, M_MULHSU, M_MULHU, M_DIV, M_DIVU, M_REM, M_REMU,
    M_ILL_BR, M_ILL_LD, M_ILL_ST, M_ILL_OP, M_ILL_OPC,
    M_COUNT
  } mnem_t;

  // ---------------- reference model (instruction-level) ----------------
  function automatic bit is_m(mnem_t m);
    return m inside {M_MUL, M_MULH, M_MULHSU, M_MULHU, M_DIV, M_DIVU, M_REM, M_REMU};
  endfunction

  function automatic bit is_nop(mnem_t m);
    return (m inside {M_ILL_BR, M_ILL_LD, M_ILL_ST, M_ILL_OP, M_ILL_OPC}) || (is_m(m) && !HAS_M);
  endfunction

  function automatic bit is_branch(mnem_t m);
    return m inside {M_BEQ, M_BNE, M_BLT, M_BGE, M_BLTU, M_BGEU};
  endfunction

  function automatic bit is_load(mnem_t m);
    return m inside {M_LB, M_LH, M_LW, M_LBU, M_LHU};
  endfunction

  function automatic bit is_store(mnem_t m);
    return m inside {M_SB, M_SH, M_SW};
  endfunction

  function automatic logic [31:0] enc(mnem_t m);
    logic [31:0] w;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    w  = $urandom;
    f3 = w[14:12];
    f7 = w[31:25];
    op = 7'b0000000;
    case (m)
      M_LUI:   op = 7'b0110111;
      M_AUIPC: op = 7'b0010111;
      M_JAL:   op = 7'b1101111;
      M_JALR:  begin op = 7'b1100111; f3 = 3'd0; end
      M_BEQ:   begin op = 7'b1100011; f3 = 3'd0; end
      M_BNE:   begin op = 7'b1100011; f3 = 3'd1; end
      M_BLT:   begin op = 7'b1100011; f3 = 3'd4; end
      M_BGE:   begin op = 7'b1100011; f3 = 3'd5; end
      M_BLTU:  begin op = 7'b1100011; f3 = 3'd6; end
      M_BGEU:  begin op = 7'b1100011; f3 = 3'd7; end
      M_LB:    begin op = 7'b0000011; f3 = 3'd0; end
      M_LH:    begin op = 7'b0000011; f3 = 3'd1; end
      M_LW:    begin op = 7'b0000011; f3 = 3'd2; end
      M_LBU:   begin op = 7'b0000011; f3 = 3'd4; end
      M_LHU:   begin op = 7'b0000011; f3 = 3'd5; end
      M_SB:    begin op = 7'b0100011; f3 = 3'd0; end
      M_SH:    begin op = 7'b0100011; f3 = 3'd1; end
      M_SW:    begin op = 7'b0100011; f3 = 3'd2; end
      M_ADDI:  begin op = 7'b0010011; f3 = 3'd0; end
      M_SLTI:  begin op = 7'b0010011; f3 = 3'd2; end
      M_SLTIU: begin op = 7'b0010011; f3 = 3'd3; end
      M_XORI:  begin op = 7'b0010011; f3 = 3'd4; end
      M_ORI:   begin op = 7'b0010011; f3 = 3'd6; end
      M_ANDI:  begin op = 7'b0010011; f3 = 3'd7; end
      M_SLLI:  begin op = 7'b0010011; f3 = 3'd1; f7 = 7'b0000000; end
      M_SRLI:  begin op = 7'b0010011; f3 = 3'd5; f7 = 7'b0000000; end
      M_SRAI:  begin op = 7'b0010011; f3 = 3'd5; f7 = 7'b0100000; end
      M_ADD:   begin op = 7'b0110011; f3 = 3'd0; f7 = 7'b0000000; end
      M_SUB:   begin op = 7'b0110011; f3 = 3'd0; f7 = 7'b0100000; end
      M_SLL:   begin op = 7'b0110011; f3 = 3'd1; f7 = 7'b0000000; end
      M_SLT:   begin op = 7'b0110011; f3 = 3'd2; f7 = 7'b0000000; end
      M_SLTU:  begin op = 7'b0110011; f3 = 3'd3; f7 = 7'b0000000; end
      M_XOR:   begin op = 7'b0110011; f3 = 3'd4; f7 = 7'b0000000; end
      M_SRL:   begin op = 7'b0110011; f3 = 3'd5; f7 = 7'b0000000; end
      M_SRA:   begin op = 7'b0110011; f3 = 3'd5; f7 = 7'b0100000; end
      M_OR:    begin op = 7'b0110011; f3 = 3'd6; f7 = 7'b0000000; end
      M_AND:   begin op = 7'b0110011; f3 = 3'd7; f7 = 7'b0000000; end
      M_MUL:   begin op = 7'b0110011; f3 = 3'd0; f7 = 7'b0000001; end
      M_MULH:  begin op = 7'b0110011; f3 = 3'd1; f7 = 7'b0000001; end
      M_MULHSU:begin op = 7'b0110011; f3 = 3'd2; f7 = 7'b0000001; end
      M_MULHU: begin op = 7'b0110011; f3 = 3'd3; f7 = 7'b0000001; end
      M_DIV:   begin op = 7'b0110011; f3 = 3'd4; f7 = 7'b0000001; end
      M_DIVU:  begin op = 7'b0110011; f3 = 3'd5; f7 = 7'b0000001; end
      M_REM:   begin op = 7'b0110011; f3 = 3'd6; f7 = 7'b0000001; end
      M_REMU:  begin op = 7'b0110011; f3 = 3'd7; f7 = 7'b0000001; end
      M_ILL_BR: begin op = 7'b1100011; f3 = ($urandom_range(0, 1) == 0) ? 3'd2 : 3'd3; end
      M_ILL_LD: begin
        op = 7'b0000011;
        case ($urandom_range(0, 2))
          0:       f3 = 3'd3;
          1:       f3 = 3'd6;
          default: f3 = 3'd7;
        endcase
      end
      M_ILL_ST: begin op = 7'b0100011; f3 = 3'($urandom_range(3, 7)); end
      M_ILL_OP: begin
        op = 7'b0110011;
        if ($urandom_range(0, 1) == 0) begin
          f7 = 7'b0100000;
          case ($urandom_range(0, 5))
            0:       f3 = 3'd1;
            1:       f3 = 3'd2;
            2:       f3 = 3'd3;
            3:       f3 = 3'd4;
            4:       f3 = 3'd6;
            default: f3 = 3'd7;
          endcase
        end else begin
          f7 = ($urandom_range(0, 1) == 0) ? 7'b1111111 : 7'b0000010;
        end
      end
      default: begin
        case ($urandom_range(0, 3))
          0:       op = 7'b0000000;
          1:       op = 7'b1111111;
          2:       op = 7'b0001111;
          default: op = 7'b1110011;
        endcase
      end
    endcase
    return {f7, w[24:15], f3, w[11:7], op};
  endfunction

  function automatic logic [31:0] exp_alu(mnem_t m, logic [31:0] a, logic [31:0] b,
                                          logic [31:0] pc, logic [31:0] imm);
    longint sa, sb, si, ub, r;
    longint unsigned pu;
    sa = $signed(a);
    sb = $signed(b);
    si = $signed(imm);
    ub = {32'h0, b};
    pu = {32'h0, a} * {32'h0, b};
    r  = {32'h0, a} + {32'h0, b};
    if (is_nop(m)) return r[31:0];
    case (m)
      M_LUI:                                   r = imm;
      M_AUIPC, M_JAL, M_BEQ, M_BNE, M_BLT,
      M_BGE, M_BLTU, M_BGEU:                   r = pc + imm;
      M_JALR:                                  r = (a + imm) & 32'hFFFF_FFFE;
      M_LB, M_LH, M_LW, M_LBU, M_LHU,
      M_SB, M_SH, M_SW, M_ADDI:                r = a + imm;
      M_SLTI:  r = (sa < si) ? 1 : 0;
      M_SLTIU: r = (a < imm) ? 1 : 0;
      M_XORI:  r = a ^ imm;
      M_ORI:   r = a | imm;
      M_ANDI:  r = a & imm;
      M_SLLI:  r = a << imm[4:0];
      M_SRLI:  r = a >> imm[4:0];
      M_SRAI:  r = sa >>> imm[4:0];
      M_ADD:   r = a + b;
      M_SUB:   r = a - b;
      M_SLL:   r = a << b[4:0];
      M_SLT:   r = (sa < sb) ? 1 : 0;
      M_SLTU:  r = (a < b) ? 1 : 0;
      M_XOR:   r = a ^ b;
      M_SRL:   r = a >> b[4:0];
      M_SRA:   r = sa >>> b[4:0];
      M_OR:    r = a | b;
      M_AND:   r = a & b;
      M_MUL:   r = sa * sb;
      M_MULH:  r = (sa * sb) >>> 32;
      M_MULHSU:r = (sa * ub) >>> 32;
      M_MULHU: r = longint'(pu >> 32);
      M_DIV:   r = (b == 0) ? 64'hFFFF_FFFF : sa / sb;
      M_DIVU:  r = (b == 0) ? 64'hFFFF_FFFF : a / b;
      M_REM:   r = (b == 0) ? {32'h0, a} : sa % sb;
      M_REMU:  r = (b == 0) ? {32'h0, a} : a % b;
      default: ;
    endcase
    return r[31:0];
  endfunction

  function automatic logic exp_taken(mnem_t m, logic [31:0] a, logic [31:0] b);
    case (m)
      M_BEQ:  return a == b;
      M_BNE:  return a != b;
      M_BLT:  return $signed(a) < $signed(b);
      M_BGE:  return $signed(a) >= $signed(b);
      M_BLTU: return a < b;
      M_BGEU: return a >= b;
      M_JAL, M_JALR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] exp_imm(mnem_t m);
    if (is_nop(m)) return 4'b0000;
    if (m inside {M_LUI, M_AUIPC}) return 4'b0100;
    if (m == M_JAL) return 4'b0101;
    if (is_branch(m)) return 4'b0011;
    if (is_store(m)) return 4'b0010;
    if (m == M_JALR || is_load(m) ||
        m inside {M_ADDI, M_SLTI, M_SLTIU, M_XORI, M_ORI, M_ANDI, M_SLLI, M_SRLI, M_SRAI})
      return 4'b0001;
    return 4'b0000;
  endfunction

  function automatic logic [3:0] exp_mr(mnem_t m);
    case (m)
      M_LB: return 4'b1000; M_LH: return 4'b1001; M_LW: return 4'b1010;
      M_LBU: return 4'b1100; M_LHU: return 4'b1101;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [2:0] exp_mw(mnem_t m);
    case (m)
      M_SB: return 3'b100; M_SH: return 3'b101; M_SW: return 3'b110;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic exp_we(mnem_t m);
    return !(is_nop(m) || is_branch(m) || is_store(m));
  endfunction

  function automatic logic [1:0] exp_wsel(mnem_t m);
    if (is_load(m)) return 2'b00;
    if (m inside {M_JAL, M_JALR}) return 2'b11;
    return 2'b01;
  endfunction

  // moves an instruction into EX; a taken branch in EX first drains as a bubble
  task automatic load_instr(input logic [31:0] ins);
    @(negedge CLK);
    if (BRANCH_TAKEN) @(negedge CLK);
    INSTRUCTION = ins;
    @(posedge CLK);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    RESET = 1'b0; STALL = 1'b0; INSTRUCTION = 32'h0;
    OP1 = 32'd3; OP2 = 32'd4; PC_EX = 32'h40; IMM_EX = 32'h99;
    #2;
    n_checks++;
    if ({MEM_READ, MEM_WRITE, REG_WRITE_EN, REG_WRITE_SELECT, BRANCH_TAKEN} !== 11'h0)
      $display("FAIL reset_ctrl: got mr=%b mw=%b we=%b ws=%b bt=%b, want all 0",
               MEM_READ, MEM_WRITE, REG_WRITE_EN, REG_WRITE_SELECT, BRANCH_TAKEN);
    else n_pass++;
    n_checks++;
    if (ALU_OUT !== 32'd7) $display("FAIL reset_alu: got %h want %h", ALU_OUT, 32'd7);
    else n_pass++;
    @(negedge CLK);
    RESET = 1'b1;

    // asynchronous clear of a live load (MEM_READ and REG_WRITE_EN set)
    load_instr(enc(M_LW));
    OP1 = 32'h10; OP2 = 32'h22; #1;
    n_checks++;
    if (MEM_READ !== 4'b1010 || REG_WRITE_EN !== 1'b1)
      $display("FAIL reset_preload: got mr=%b we=%b want 1010/1", MEM_READ, REG_WRITE_EN);
    else n_pass++;
    RESET = 1'b0; #1;
    n_checks++;
    if ({MEM_READ, MEM_WRITE, REG_WRITE_EN, REG_WRITE_SELECT, BRANCH_TAKEN} !== 11'h0 ||
        ALU_OUT !== 32'h32)
      $display("FAIL reset_async: got mr=%b mw=%b we=%b ws=%b bt=%b alu=%h, want 0s alu=00000032",
               MEM_READ, MEM_WRITE, REG_WRITE_EN, REG_WRITE_SELECT, BRANCH_TAKEN, ALU_OUT);
    else n_pass++;
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  task automatic test_add_sub;
    load_instr(enc(M_ADD));
    OP1 = 32'd7; OP2 = 32'd5; #1;
    n_checks++;
    if (ALU_OUT !== 32'd12 || REG_WRITE_EN !== 1'b1 || REG_WRITE_SELECT !== 2'b01)
      $display("FAIL add: got alu=%0d we=%b ws=%b want 12/1/01", ALU_OUT, REG_WRITE_EN, REG_WRITE_SELECT);
    else n_pass++;
    load_instr(enc(M_SUB));
    OP1 = 32'd7; OP2 = 32'd5; #1;
    n_checks++;
    if (ALU_OUT !== 32'd2 || REG_WRITE_EN !== 1'b1 || REG_WRITE_SELECT !== 2'b01)
      $display("FAIL sub: got alu=%0d we=%b ws=%b want 2/1/01", ALU_OUT, REG_WRITE_EN, REG_WRITE_SELECT);
    else n_pass++;
  endtask

  task automatic test_branch_bubble;
    load_instr(enc(M_BEQ));
    OP1 = 32'd9; OP2 = 32'd9; PC_EX = 32'h100; IMM_EX = 32'h20; #1;
    n_checks++;
    if (BRANCH_TAKEN !== 1'b1 || ALU_OUT !== 32'h120)
      $display("FAIL beq: got bt=%b alu=%h want 1/00000120", BRANCH_TAKEN, ALU_OUT);
    else n_pass++;
    @(negedge CLK);
    INSTRUCTION = enc(M_SW);
    @(posedge CLK); #1;
    n_checks++;
    if (REG_WRITE_EN !== 1'b0 || MEM_WRITE !== 3'b000 || BRANCH_TAKEN !== 1'b0)
      $display("FAIL beq_bubble: got we=%b mw=%b bt=%b want 0/000/0", REG_WRITE_EN, MEM_WRITE, BRANCH_TAKEN);
    else n_pass++;
  endtask

  task automatic test_load_store;
    load_instr(enc(M_LW));
    #1;
    n_checks++;
    if (MEM_READ !== 4'b1010 || REG_WRITE_SELECT !== 2'b00)
      $display("FAIL lw: got mr=%b ws=%b want 1010/00", MEM_READ, REG_WRITE_SELECT);
    else n_pass++;
    load_instr(enc(M_SB));
    OP1 = 32'h1000; OP2 = 32'hDEAD; IMM_EX = 32'h24; #1;
    n_checks++;
    if (MEM_WRITE !== 3'b100 || ALU_OUT !== 32'h1024 || REG_WRITE_EN !== 1'b0)
      $display("FAIL sb: got mw=%b alu=%h we=%b want 100/00001024/0", MEM_WRITE, ALU_OUT, REG_WRITE_EN);
    else n_pass++;
  endtask

  task automatic test_stall;
    load_instr(enc(M_ADD));
    @(negedge CLK);
    STALL = 1'b1;
    INSTRUCTION = enc(M_SW);
    for (int k = 0; k < 2; k++) begin
      @(posedge CLK); #1;
      n_checks++;
      if (REG_WRITE_EN !== 1'b1 || MEM_WRITE !== 3'b000)
        $display("FAIL stall_hold%0d: got we=%b mw=%b want 1/000", k, REG_WRITE_EN, MEM_WRITE);
      else n_pass++;
    end
    @(negedge CLK);
    STALL = 1'b0;
    @(posedge CLK); #1;
    n_checks++;
    if (REG_WRITE_EN !== 1'b0 || MEM_WRITE !== 3'b110)
      $display("FAIL stall_release: got we=%b mw=%b want 0/110", REG_WRITE_EN, MEM_WRITE);
    else n_pass++;
  endtask

  task automatic test_branch_stall;
    load_instr(enc(M_BNE));
    OP1 = 32'd1; OP2 = 32'd2; #1;
    @(negedge CLK);
    STALL = 1'b1;
    INSTRUCTION = enc(M_ADD);
    for (int k = 0; k < 2; k++) begin
      @(posedge CLK); #1;
      n_checks++;
      if (BRANCH_TAKEN !== 1'b1 || REG_WRITE_EN !== 1'b0)
        $display("FAIL br_stall%0d: got bt=%b we=%b want 1/0", k, BRANCH_TAKEN, REG_WRITE_EN);
      else n_pass++;
    end
    @(negedge CLK);
    STALL = 1'b0;
    @(posedge CLK); #1;
    n_checks++;
    if (BRANCH_TAKEN !== 1'b0 || REG_WRITE_EN !== 1'b0)
      $display("FAIL br_stall_bubble: got bt=%b we=%b want 0/0", BRANCH_TAKEN, REG_WRITE_EN);
    else n_pass++;
    @(posedge CLK); #1;
    n_checks++;
    if (REG_WRITE_EN !== 1'b1)
      $display("FAIL br_stall_next: got we=%b want 1", REG_WRITE_EN);
    else n_pass++;
  endtask

  task automatic test_reset_mid_stall;
    load_instr(enc(M_LW));
    @(negedge CLK);
    STALL = 1'b1;
    #2 RESET = 1'b0;
    #1;
    n_checks++;
    if (REG_WRITE_EN !== 1'b0 || MEM_READ !== 4'b0000)
      $display("FAIL reset_stall: got we=%b mr=%b want 0/0000", REG_WRITE_EN, MEM_READ);
    else n_pass++;
    @(negedge CLK);
    RESET = 1'b1;
    STALL = 1'b0;
  endtask

  task automatic test_div;
    logic [31:0] exp;
    load_instr(enc(M_DIV));
    OP1 = 32'h8000_0000; OP2 = 32'hFFFF_FFFF; #1;
    exp = HAS_M ? 32'h8000_0000 : 32'h7FFF_FFFF;
    n_checks++;
    if (ALU_OUT !== exp || REG_WRITE_EN !== HAS_M)
      $display("FAIL div_ovf: got alu=%h we=%b want %h/%b", ALU_OUT, REG_WRITE_EN, exp, HAS_M);
    else n_pass++;
    load_instr(enc(M_DIVU));
    OP1 = 32'h1234; OP2 = 32'h0; #1;
    exp = HAS_M ? 32'hFFFF_FFFF : 32'h1234;
    n_checks++;
    if (ALU_OUT !== exp || REG_WRITE_EN !== HAS_M)
      $display("FAIL divu_zero: got alu=%h we=%b want %h/%b", ALU_OUT, REG_WRITE_EN, exp, HAS_M);
    else n_pass++;
  endtask

  task automatic test_random;
    mnem_t       m;
    logic [31:0] a, b, pc, imm;
    for (int i = 0; i < 400; i++) begin
      m = mnem_t'($urandom_range(0, int'(M_COUNT) - 1));
      @(negedge CLK);
      if (BRANCH_TAKEN) @(negedge CLK);
      INSTRUCTION = enc(m);
      #1;
      n_checks++;
      if (IMMEDIATE_SELECT !== exp_imm(m))
        $display("FAIL rnd_immsel %s: got %b want %b", m.name(), IMMEDIATE_SELECT, exp_imm(m));
      else n_pass++;
      @(posedge CLK); #1;
      a = $urandom; b = $urandom; pc = $urandom; imm = $urandom;
      case ($urandom_range(0, 7))
        0: b = a;
        1: b = 32'h0;
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: begin a = $urandom_range(0, 20); b = $urandom_range(0, 20); imm = $urandom_range(0, 40); end
        default: ;
      endcase
      OP1 = a; OP2 = b; PC_EX = pc; IMM_EX = imm;
      #1;
      n_checks++;
      if (ALU_OUT !== exp_alu(m, a, b, pc, imm))
        $display("FAIL rnd_alu %s: a=%h b=%h pc=%h imm=%h got %h want %h",
                 m.name(), a, b, pc, imm, ALU_OUT, exp_alu(m, a, b, pc, imm));
      else n_pass++;
      n_checks++;
      if (BRANCH_TAKEN !== exp_taken(m, a, b))
        $display("FAIL rnd_taken %s: a=%h b=%h got %b want %b", m.name(), a, b, BRANCH_TAKEN, exp_taken(m, a, b));
      else n_pass++;
      n_checks++;
      if (MEM_READ !== exp_mr(m) || MEM_WRITE !== exp_mw(m))
        $display("FAIL rnd_mem %s: got mr=%b mw=%b want %b/%b", m.name(), MEM_READ, MEM_WRITE, exp_mr(m), exp_mw(m));
      else n_pass++;
      n_checks++;
      if (REG_WRITE_EN !== exp_we(m))
        $display("FAIL rnd_we %s: got %b want %b", m.name(), REG_WRITE_EN, exp_we(m));
      else n_pass++;
      if (exp_we(m)) begin
        n_checks++;
        if (REG_WRITE_SELECT !== exp_wsel(m))
          $display("FAIL rnd_wsel %s: got %b want %b", m.name(), REG_WRITE_SELECT, exp_wsel(m));
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_branch_bubble();
    test_load_store();
    test_stall();
    test_branch_stall();
    test_reset_mid_stall();
    test_div();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
